// File: rtl/p874x_pkg.sv
// p874x_pkg: shared constants and helpers for the P874x bus mailbox.
//   BUS_W             - width of the core data bus
//   EMPTY_VAL_DEFAULT - byte returned on a bus read of an empty to-MCU FIFO
//   cnt_w()           - width of an occupancy count able to hold 0..depth
package p874x_pkg;
   localparam int BUS_W = 8;
   localparam logic [BUS_W-1:0] EMPTY_VAL_DEFAULT = 8'hFF;
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/p874x_sync_fifo.sv
// p874x_sync_fifo: single-clock FIFO with exact occupancy count.
//   clk, rstb   - clock, asynchronous active-low reset (empties the FIFO)
//   push, din   - write request and data; accepted if not full or if a pop
//                 happens in the same cycle
//   pop         - read request; ignored while empty
//   head        - oldest entry (stale while empty)
//   full, empty - status
//   count       - occupancy, 0..DEPTH
module p874x_sync_fifo
   import p874x_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      push,
   input  logic [WIDTH-1:0]          din,
   input  logic                      pop,
   output logic [WIDTH-1:0]          head,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_eff, pop_eff;

   assign empty    = count_q == '0;
   assign full     = count_q == CW'(DEPTH);
   assign pop_eff  = pop && !empty;
   // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
   assign push_eff = push && (!full || pop_eff);
   assign head     = mem_q[rd_ptr_q];
   assign count    = count_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_eff) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push_eff) - CW'(pop_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (push_eff) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/p874x_bus_mailbox.sv
// p874x_bus_mailbox: address-less RDb/WRb bus responder bridging the core to a host.
//   clk, rstb                 - core clock, asynchronous active-low reset
//   bus_wrb, bus_wdata        - core write strobe (active low) and data -> to-host FIFO
//   bus_rdb, bus_rdata        - core read strobe (active low) and data <- to-MCU FIFO
//   intb                      - active-low interrupt while MCU-bound data waits
//   host_wdata/wvalid/wready  - host stream into the to-MCU FIFO
//   host_rdata/rvalid/rready  - host stream out of the to-host FIFO
//   to_mcu_count/to_host_count - FIFO occupancies
//   ovf, unf, clr_flags       - sticky drop / empty-read flags and their clear
module p874x_bus_mailbox
   import p874x_pkg::*;
#(
   parameter int               DEPTH       = 8,
   parameter logic [BUS_W-1:0] EMPTY_VAL   = EMPTY_VAL_DEFAULT,
   parameter bit               IRQ_ON_DATA = 1'b1
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    bus_wrb,
   input  logic                    bus_rdb,
   input  logic [BUS_W-1:0]        bus_wdata,
   output logic [BUS_W-1:0]        bus_rdata,
   output logic                    intb,
   input  logic [BUS_W-1:0]        host_wdata,
   input  logic                    host_wvalid,
   output logic                    host_wready,
   output logic [BUS_W-1:0]        host_rdata,
   output logic                    host_rvalid,
   input  logic                    host_rready,
   output logic [cnt_w(DEPTH)-1:0] to_mcu_count,
   output logic [cnt_w(DEPTH)-1:0] to_host_count,
   output logic                    ovf,
   output logic                    unf,
   input  logic                    clr_flags
);
   logic             wrb_q, rdb_q, armed_q, rd_hit_q, ovf_q, unf_q, intb_q;
   logic             armed_d, rd_hit_d, ovf_d, unf_d, intb_d;
   logic             wr_fall, rd_fall, rd_rise;
   logic             m_full, m_empty, m_pop, h_full, h_empty;
   logic [BUS_W-1:0] m_head;

   // Edges only count once both strobes have been seen high after reset, so a
   // strobe held low across reset release is not mistaken for a transaction.
   assign wr_fall = armed_q && !bus_wrb && wrb_q;
   assign rd_fall = armed_q && !bus_rdb && rdb_q;
   assign rd_rise = armed_q && bus_rdb && !rdb_q;
   assign m_pop   = rd_rise && rd_hit_q;

   p874x_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BUS_W)) u_to_mcu (
      .clk(clk), .rstb(rstb),
      .push(host_wvalid && !m_full), .din(host_wdata), .pop(m_pop),
      .head(m_head), .full(m_full), .empty(m_empty), .count(to_mcu_count)
   );

   p874x_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BUS_W)) u_to_host (
      .clk(clk), .rstb(rstb),
      .push(wr_fall), .din(bus_wdata), .pop(host_rready),
      .head(host_rdata), .full(h_full), .empty(h_empty), .count(to_host_count)
   );

   assign host_wready = !m_full;
   assign host_rvalid = !h_empty;
   assign ovf         = ovf_q;
   assign unf         = unf_q;
   assign intb        = intb_q;

   // After the fall cycle the read outcome is frozen in rd_hit_q, so host
   // pushes landing mid-read cannot change what the core samples.
   assign bus_rdata = ((!bus_rdb && !rdb_q) ? rd_hit_q : !m_empty) ? m_head : EMPTY_VAL;

   always_comb begin
      armed_d  = armed_q || (bus_wrb && bus_rdb);
      rd_hit_d = rd_fall ? !m_empty : (rd_rise ? 1'b0 : rd_hit_q);
      // A full FIFO implies non-empty, so host_rready here is a real pop.
      ovf_d    = (wr_fall && h_full && !host_rready) || (ovf_q && !clr_flags);
      unf_d    = (rd_fall && m_empty) || (unf_q && !clr_flags);
      intb_d   = !(IRQ_ON_DATA && (to_mcu_count != '0));
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wrb_q    <= 1'b1;
         rdb_q    <= 1'b1;
         armed_q  <= 1'b0;
         rd_hit_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         intb_q   <= 1'b1;
      end else begin
         wrb_q    <= bus_wrb;
         rdb_q    <= bus_rdb;
         armed_q  <= armed_d;
         rd_hit_q <= rd_hit_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         intb_q   <= intb_d;
      end
   end
endmodule

// File: tb/tb_p874x_bus_mailbox.sv
// tb_p874x_bus_mailbox: directed self-checking bench for p874x_bus_mailbox (DEPTH 8).
module tb_p874x_bus_mailbox;
   logic       clk = 1'b0;
   logic       rstb = 1'b0;
   logic       bus_wrb = 1'b1, bus_rdb = 1'b1;
   logic [7:0] bus_wdata = '0, bus_rdata;
   logic       intb;
   logic [7:0] host_wdata = '0, host_rdata;
   logic       host_wvalid = 1'b0, host_wready, host_rvalid, host_rready = 1'b0;
   logic [3:0] to_mcu_count, to_host_count;
   logic       ovf, unf, clr_flags = 1'b0;
   int         checks = 0, failures = 0;
   logic [7:0] drain_exp [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};

   p874x_bus_mailbox dut (
      .clk(clk), .rstb(rstb), .bus_wrb(bus_wrb), .bus_rdb(bus_rdb),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .intb(intb),
      .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_rready(host_rready),
      .to_mcu_count(to_mcu_count), .to_host_count(to_host_count),
      .ovf(ovf), .unf(unf), .clr_flags(clr_flags)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      check("rst_mcu_cnt", to_mcu_count, 0);
      check("rst_host_cnt", to_host_count, 0);
      check("rst_intb", intb, 1);
      check("rst_ovf", ovf, 0);
      check("rst_unf", unf, 0);
      check("rst_rdata", bus_rdata, 8'hFF);
      check("rst_rvalid", host_rvalid, 0);
      check("rst_wready", host_wready, 1);
      rstb = 1'b1;
      tick();
      // host pushes 3C, A5; two single-cycle reads
      host_wvalid = 1'b1; host_wdata = 8'h3C;
      tick();
      host_wdata = 8'hA5;
      tick();
      host_wvalid = 1'b0;
      check("t1_cnt2", to_mcu_count, 2);
      check("t1_intb_lo", intb, 0);
      bus_rdb = 1'b0; #1;
      check("t1_rd1", bus_rdata, 8'h3C);
      tick();
      bus_rdb = 1'b1;
      tick();
      check("t1_cnt1", to_mcu_count, 1);
      bus_rdb = 1'b0; #1;
      check("t1_rd2", bus_rdata, 8'hA5);
      tick();
      bus_rdb = 1'b1;
      tick();
      check("t1_cnt0", to_mcu_count, 0);
      check("t1_intb_still_lo", intb, 0);
      tick();
      check("t1_intb_hi", intb, 1);
      // read of empty FIFO
      bus_rdb = 1'b0; #1;
      check("t2_rd_fall", bus_rdata, 8'hFF);
      tick();
      check("t2_unf", unf, 1);
      check("t2_rd_low", bus_rdata, 8'hFF);
      bus_rdb = 1'b1;
      tick();
      check("t2_cnt", to_mcu_count, 0);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("t2_unf_clr", unf, 0);
      // nine writes into an 8-deep to-host FIFO
      for (int i = 1; i <= 9; i++) begin
         bus_wdata = 8'(i); bus_wrb = 1'b0;
         tick();
         bus_wrb = 1'b1;
         tick();
      end
      check("t3_cnt", to_host_count, 8);
      check("t3_ovf", ovf, 1);
      check("t3_head", host_rdata, 8'h01);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("t3_ovf_clr", ovf, 0);
      // write while full with simultaneous host pop
      bus_wdata = 8'hAA; bus_wrb = 1'b0; host_rready = 1'b1;
      tick();
      bus_wrb = 1'b1; host_rready = 1'b0;
      check("t4_cnt", to_host_count, 8);
      check("t4_ovf", ovf, 0);
      host_rready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("t4_drain%0d", k), host_rdata, drain_exp[k]);
         tick();
      end
      host_rready = 1'b0;
      check("t4_empty", to_host_count, 0);
      check("t4_rvalid", host_rvalid, 0);
      // host push during an empty-at-fall read
      bus_rdb = 1'b0; #1;
      check("t5_fall", bus_rdata, 8'hFF);
      tick();
      host_wvalid = 1'b1; host_wdata = 8'h55;
      tick();
      host_wvalid = 1'b0; #1;
      check("t5_low", bus_rdata, 8'hFF);
      check("t5_cnt_mid", to_mcu_count, 1);
      bus_rdb = 1'b1;
      tick();
      check("t5_nopop", to_mcu_count, 1);
      bus_rdb = 1'b0; #1;
      check("t5_rd55", bus_rdata, 8'h55);
      tick();
      bus_rdb = 1'b1;
      tick();
      check("t5_cnt0", to_mcu_count, 0);
      // reset mid-operation with bus_wrb held low across release
      host_wvalid = 1'b1; host_wdata = 8'h11;
      tick();
      host_wvalid = 1'b0;
      bus_wdata = 8'h22; bus_wrb = 1'b0;
      tick();
      bus_wrb = 1'b1;
      tick();
      check("t6_mcu_cnt", to_mcu_count, 1);
      check("t6_host_cnt", to_host_count, 1);
      check("t6_intb_lo", intb, 0);
      check("t6_unf_pre", unf, 1);
      bus_wdata = 8'h77; bus_wrb = 1'b0; rstb = 1'b0; #1;
      check("t6_rst_mcu", to_mcu_count, 0);
      check("t6_rst_host", to_host_count, 0);
      check("t6_rst_intb", intb, 1);
      check("t6_rst_unf", unf, 0);
      check("t6_rst_ovf", ovf, 0);
      tick();
      rstb = 1'b1;
      tick();
      tick();
      check("t6_no_push", to_host_count, 0);
      bus_wrb = 1'b1;
      tick();
      bus_wdata = 8'h88; bus_wrb = 1'b0;
      tick();
      bus_wrb = 1'b1;
      check("t6_push_cnt", to_host_count, 1);
      check("t6_push_data", host_rdata, 8'h88);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
